// File: rtl/regbank_write_arbiter.sv
// Round-robin write arbiter for a latch-based register bank.
// Each write is sequenced as setup / one-cycle enable / hold / acknowledge.
module regbank_write_arbiter #(
    parameter int NREQ        = 4,
    parameter int NUM_REGS    = 8,
    parameter int AW          = 3,
    parameter int DW          = 32,
    parameter int HOLD_CYCLES = 1,
    localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic [NUM_REGS-1:0]  reg_en,
    output logic [DW-1:0]        reg_d,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        ACK
    } state_t;

    state_t              state_reg, state_next;
    logic [GW-1:0]       rr_reg, rr_next;
    logic [GW-1:0]       grant_reg, grant_next;
    logic [AW-1:0]       addr_lat_reg, addr_lat_next;
    logic [1:0]          hold_cnt_reg, hold_cnt_next;
    logic [NREQ-1:0]     ack_reg, ack_next;
    logic                err_reg, err_next;
    logic [NUM_REGS-1:0] reg_en_reg, reg_en_next;
    logic [DW-1:0]       reg_d_reg, reg_d_next;
    logic                busy_reg, busy_next;

    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic [AW-1:0]       pick_addr;
    logic [DW-1:0]       pick_data;
    logic                addr_oor;
    logic [NUM_REGS-1:0] addr_onehot;
    logic [NREQ-1:0]     grant_onehot;

    // Lowest rotation offset from rr_reg wins; descending scan lets it overwrite.
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_reg) + k) % NREQ;
            if (req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    assign pick_addr = addr[int'(pick_idx)*AW +: AW];
    assign pick_data = wdata[int'(pick_idx)*DW +: DW];
    assign addr_oor  = (32'(addr_lat_reg) >= 32'(NUM_REGS));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_sel
            assign addr_onehot[gi] = (32'(addr_lat_reg) == 32'(gi));
        end
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack_sel
            assign grant_onehot[gi] = (32'(grant_reg) == 32'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        rr_next       = rr_reg;
        grant_next    = grant_reg;
        addr_lat_next = addr_lat_reg;
        hold_cnt_next = hold_cnt_reg;
        reg_d_next    = reg_d_reg;
        reg_en_next   = '0;
        ack_next      = '0;
        err_next      = 1'b0;
        busy_next     = busy_reg;
        unique case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (pick_found) begin
                    grant_next    = pick_idx;
                    addr_lat_next = pick_addr;
                    reg_d_next    = pick_data;
                    busy_next     = 1'b1;
                    state_next    = SETUP;
                end
            end
            SETUP: begin
                state_next = WRITE;
                if (!addr_oor) begin
                    reg_en_next = addr_onehot;
                end
            end
            WRITE: begin
                state_next    = HOLD;
                hold_cnt_next = 2'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (hold_cnt_reg == 2'd0) begin
                    state_next = ACK;
                    ack_next   = grant_onehot;
                    err_next   = addr_oor;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 2'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                // The just-served requester drops to lowest priority.
                if (32'(grant_reg) == 32'(NREQ - 1)) begin
                    rr_next = '0;
                end else begin
                    rr_next = grant_reg + GW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_reg       <= '0;
            grant_reg    <= '0;
            addr_lat_reg <= '0;
            hold_cnt_reg <= '0;
            ack_reg      <= '0;
            err_reg      <= 1'b0;
            reg_en_reg   <= '0;
            reg_d_reg    <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_reg       <= rr_next;
            grant_reg    <= grant_next;
            addr_lat_reg <= addr_lat_next;
            hold_cnt_reg <= hold_cnt_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            reg_en_reg   <= reg_en_next;
            reg_d_reg    <= reg_d_next;
            busy_reg     <= busy_next;
        end
    end

    assign ack      = ack_reg;
    assign err      = err_reg;
    assign reg_en   = reg_en_reg;
    assign reg_d    = reg_d_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_regbank_write_arbiter;
    localparam int NREQ     = 4;
    localparam int NUM_REGS = 6;
    localparam int AW       = 3;
    localparam int DW       = 32;
    localparam int HOLD     = 1;
    localparam int GW       = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [NUM_REGS-1:0] reg_en;
    logic [DW-1:0]       reg_d;
    logic                busy;
    logic [GW-1:0]       grant_id;

    int passed = 0;
    int total  = 0;

    regbank_write_arbiter #(
        .NREQ(NREQ), .NUM_REGS(NUM_REGS), .AW(AW), .DW(DW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .reg_en(reg_en), .reg_d(reg_d),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction model: a grant starts a timeline t=0..3+HOLD; outputs are a function of t.
    bit          m_valid = 1'b0;
    bit          m_active;
    int          m_t, m_win, m_rr, m_addr, m_idx;
    logic [DW-1:0] m_d;
    int          grants[$];

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1; m_active = 1'b0; m_t = 0; m_win = 0; m_rr = 0; m_addr = 0; m_d = '0;
        end else if (m_active) begin
            m_t++;
            if (m_t == 3 + HOLD) begin
                m_active = 1'b0;
                m_rr = (m_win + 1) % NREQ;
            end
        end else if (req != '0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                m_idx = (m_rr + k) % NREQ;
                if (req[m_idx]) m_win = m_idx;
            end
            m_active = 1'b1;
            m_t = 0;
            m_addr = int'(addr[m_win*AW +: AW]);
            m_d = wdata[m_win*DW +: DW];
            grants.push_back(m_win);
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0]     e_ack;
        logic [NUM_REGS-1:0] e_en;
        logic                e_err;
        if (m_valid && !reset) begin
            e_ack = '0; e_en = '0; e_err = 1'b0;
            if (m_active && m_t == 1 && m_addr < NUM_REGS) e_en[m_addr] = 1'b1;
            if (m_active && m_t == 2 + HOLD) begin
                e_ack[m_win] = 1'b1;
                e_err = (m_addr >= NUM_REGS);
                $display("txn: requester %0d addr %0d data %h err %0d", m_win, m_addr, m_d, e_err);
            end
            check("ack", 64'(ack), 64'(e_ack));
            check("err", 64'(err), 64'(e_err));
            check("reg_en", 64'(reg_en), 64'(e_en));
            check("reg_d", 64'(reg_d), 64'(m_d));
            check("busy", 64'(busy), 64'(m_active));
            check("grant_id", 64'(grant_id), 64'(m_win));
        end
    end

    // Requesters drop req once they see their ack.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) req[i] = 1'b0;
    end

    task automatic raise(input int i, input int a, input logic [DW-1:0] d);
        addr[i*AW +: AW] = AW'(a);
        wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((req != '0 || busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            $display("FAIL timeout_%s: got busy=%0b req=%b required idle", tag, busy, req);
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        reset = 1'b1; req = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_reg_d", 64'(reg_d), 64'd0);
        check("reset_grant", 64'(grant_id), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write to register 5.
        raise(0, 5, 32'hDEADBEEF);
        @(negedge clk);
        check("single_reg_d", 64'(reg_d), 64'hDEADBEEF);
        check("single_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("single_en", 64'(reg_en), 64'b10_0000);
        @(negedge clk);
        check("single_en_off", 64'(reg_en), 64'd0);
        @(negedge clk);
        check("single_ack", 64'(ack), 64'b0001);
        @(negedge clk);
        check("single_idle", 64'(busy), 64'd0);
        check("single_reg_d_kept", 64'(reg_d), 64'hDEADBEEF);
        wait_idle("single");

        // Contention: rr is 1 after serving 0, so first round begins at 1.
        base = grants.size();
        for (int i = 0; i < NREQ; i++) raise(i, i, 32'h100 + 32'(i));
        wait_idle("rr1");
        for (int i = 0; i < NREQ; i++) raise(i, i + 1, 32'h200 + 32'(i));
        wait_idle("rr2");
        check("rr_order0", 64'(grants[base+0]), 64'd1);
        check("rr_order1", 64'(grants[base+1]), 64'd2);
        check("rr_order2", 64'(grants[base+2]), 64'd3);
        check("rr_order3", 64'(grants[base+3]), 64'd0);
        check("rr_order4", 64'(grants[base+4]), 64'd1);
        check("rr_order7", 64'(grants[base+7]), 64'd0);

        // Fairness wrap: serve 2, then 1001 gives 3 then 0, leaving rr at 1.
        base = grants.size();
        raise(2, 1, 32'hA2);
        wait_idle("wrap_a");
        raise(3, 2, 32'hA3);
        raise(0, 3, 32'hA0);
        wait_idle("wrap_b");
        raise(0, 4, 32'hB0);
        raise(1, 0, 32'hB1);
        wait_idle("wrap_c");
        check("wrap_g0", 64'(grants[base+0]), 64'd2);
        check("wrap_g1", 64'(grants[base+1]), 64'd3);
        check("wrap_g2", 64'(grants[base+2]), 64'd0);
        check("wrap_g3", 64'(grants[base+3]), 64'd1);

        // Out-of-range address: 7 >= NUM_REGS.
        raise(1, 7, 32'h77);
        @(negedge clk);
        @(negedge clk);
        check("oor_en", 64'(reg_en), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("oor_ack", 64'(ack), 64'b0010);
        check("oor_err", 64'(err), 64'd1);
        wait_idle("oor");

        // Data change after grant must not reach reg_d.
        raise(1, 2, 32'h1);
        @(negedge clk);
        wdata[1*DW +: DW] = 32'h2;
        @(negedge clk);
        check("latch_write", 64'(reg_d), 64'h1);
        @(negedge clk);
        check("latch_hold", 64'(reg_d), 64'h1);
        wait_idle("latch");

        // Reset mid-WRITE: rr is 2, so 0110 grants 2; retry after reset starts from 0.
        base = grants.size();
        raise(1, 1, 32'hC1);
        raise(2, 3, 32'hC2);
        @(negedge clk);
        @(negedge clk);
        check("abort_en", 64'(reg_en), 64'b00_1000);
        reset = 1'b1;
        @(negedge clk);
        check("abort_en_cut", 64'(reg_en), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ack", 64'(ack), 64'd0);
        reset = 1'b0;
        wait_idle("retry");
        check("abort_g0", 64'(grants[base+0]), 64'd2);
        check("retry_g1", 64'(grants[base+1]), 64'd1);
        check("retry_g2", 64'(grants[base+2]), 64'd2);
        check("retry_reg_d", 64'(reg_d), 64'hC2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Round-robin controller that shares one bank of NUM_REGS 32-bit gate-level registers (D-latch based, level-enabled) between NREQ write requesters.
- Picks one requester per transaction and sequences the write so the latch D input has setup and hold margin around a one-cycle enable pulse.
- Acknowledges the winner when the write is complete.
- Sits between the pipeline/bus masters and the register bank enable/D inputs.

Parameters:
NREQ, 4, number of requesters
NUM_REGS, 8, number of 32-bit registers in the bank
AW, 3, address width per requester
DW, 32, data width
HOLD_CYCLES, 1, cycles reg_d is held stable after reg_en drops (1..3)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester write request; held high until ack
addr  input  NREQ*AW  packed target register index; requester i uses bits [i*AW +: AW]
wdata  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
ack  output  NREQ  one-cycle completion pulse to the granted requester
err  output  1  one-cycle pulse coincident with ack when the latched addr >= NUM_REGS
reg_en  output  NUM_REGS  one-hot enable to register bank (drives register enable)
reg_d  output  DW  data to the register bank D inputs
busy  output  1  high from grant until the ACK state ends
grant_id  output  clog2(NREQ)  index of the current or last winner

Behaviour:
- Clock and reset:
  - Single clock domain; clk is the only clock.
  - reset is synchronous and active-high; it is sampled on the rising edge of clk.
  - All outputs are registered.
- Reset values:
  - state=IDLE, rr_ptr=0, ack=0, err=0, reg_en=0, reg_d=0, busy=0, grant_id=0.
- States: IDLE, SETUP, WRITE, HOLD, ACK.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, on the edge, pick the winner: first set bit of req searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch the winner's addr and wdata internally.
  - Drive reg_d<=wdata[winner], grant_id<=winner, busy<=1, then go to SETUP.
- SETUP:
  - One cycle with reg_en=0 and reg_d stable, giving setup margin for the D inverter path.
  - Next state is WRITE.
- WRITE:
  - One cycle with reg_en = one-hot(latched addr).
  - If latched addr >= NUM_REGS, reg_en stays all zeros.
  - Next state is HOLD.
- HOLD:
  - reg_en=0 and reg_d unchanged for HOLD_CYCLES cycles, using an internal down-counter.
  - Then go to ACK.
- ACK:
  - One cycle with ack[grant_id]=1, err=(latched addr >= NUM_REGS), busy=1.
  - rr_ptr <= (grant_id+1) mod NREQ.
  - Next state is IDLE; busy=0, ack=0, err=0 in IDLE.
- Latency: with req sampled at edge E0:
  - reg_d valid after E0.
  - reg_en high between E1 and E2.
  - ack high between E(2+HOLD_CYCLES) and E(3+HOLD_CYCLES).
  - Total of 4+HOLD_CYCLES cycles per transaction, no back-to-back overlap.
- Handshake:
  - The requester holds req, addr and wdata until it sees ack.
  - The requester drops req on the edge that ends ACK.
  - The arbiter samples req only in IDLE.
  - Changes to addr/wdata after the grant are ignored, because the values are latched.
  - If req drops before ack, the transaction still completes and ack is still issued.
- Fairness: a requester that has just been acked has the lowest priority in the next arbitration.
- Simultaneous requests: exactly one grant; every other requester waits, with its req still high.
- reg_d keeps its last value in IDLE; it is not cleared.
- At most one bit of reg_en is ever set, and only in WRITE.
- Reset mid-operation:
  - Next edge forces IDLE with reset values and no ack.
  - A reg_en pulse in flight is cut at that edge.
  - The aborted write may have partially landed; the requester must retry.

Test Plan:
- Single write: req=4'b0001, addr0=5, wdata0=32'hDEADBEEF → reg_d=DEADBEEF after E0; reg_en=8'b0010_0000 only in cycle E1–E2; ack=4'b0001 in cycle E3–E4 (HOLD_CYCLES=1); busy high E0–E4.
- Contention/round-robin: req=4'b1111 held, each requester drops req after its ack → grant order 0,1,2,3; after a re-raise with rr_ptr=0, order repeats; no ack overlaps; grant_id matches each ack.
- Fairness wrap: rr_ptr=3 after granting 2, then req=4'b1001 → requester 3 granted, then 0; rr_ptr ends at 1.
- Out-of-range address: NUM_REGS=6, addr=7 → reg_en stays 0 for the whole transaction; ack pulses; err=1 in the same cycle.
- Data change after grant: wdata1 changes from 32'h1 to 32'h2 in the SETUP cycle → reg_d stays 32'h1 through HOLD.
- Reset mid-WRITE: assert reset during the WRITE cycle → next edge gives reg_en=0, busy=0, ack never pulses, rr_ptr=0; a retried req then completes normally.
